mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Moore-style multicycle control unit. Drives every datapath control strobe of the 32-bit multicycle CPU (PC, IR, MDR, A, B and ALUOut registers, register file, unified memory).
- Sits directly upstream of the datapath. It consumes the opcode field of IR and the ALU zero flag, and produces the per-state control word.
- Also exports the current state and a retired-fetch counter for bench observation.

Parameters:
- OPW, 6, opcode field width (IR[31:26]).
- CNTW, 32, width of instr_count.

Ports:
- clock  input  1  single system clock; all state updates occur on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode  input  OPW  IR[31:26]; sampled only in DECODE and MEMADDR.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by zero; the datapath performs the AND.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  register write-data select: 1 = MDR, 0 = ALUOut.
- IRWrite  output  1  IR load.
- RegDst  output  1  destination select: 1 = rd, 0 = rt.
- RegWrite  output  1  register-file write.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  high for one cycle when an unsupported opcode is decoded.
- state  output  4  current state encoding.
- instr_count  output  CNTW  number of entries into FETCH since reset.

Behaviour:
- Reset: asynchronous on the falling edge of reset_n. Forces state = INIT (0) and instr_count = 0. All control outputs decode to 0 in INIT.
- Reset asserted mid-instruction aborts immediately; no strobe may remain asserted.
- All outputs are a pure function of the state register (Moore). opcode affects only the next state.
- State encodings and transitions (any output not listed for a state is 0):
  - 0 INIT: always -> FETCH.
  - 1 FETCH: MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. -> DECODE.
  - 2 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 0x23 (lw) or 0x2B (sw) -> MEMADDR
    - 0x00 (R-type) -> EXEC
    - 0x04 (beq) -> BRANCH
    - 0x02 (j) -> JUMP
    - 0x08 (addi) -> ADDIEX
    - any other value -> ILLEGAL
  - 3 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMREAD if opcode = 0x23, otherwise MEMWRITE.
  - 4 MEMREAD: MemRead, IorD=1. -> MEMWB.
  - 5 MEMWB: RegWrite, MemtoReg=1, RegDst=0. -> FETCH.
  - 6 MEMWRITE: MemWrite, IorD=1. -> FETCH.
  - 7 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RCOMP.
  - 8 RCOMP: RegWrite, RegDst=1, MemtoReg=0. -> FETCH.
  - 9 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. -> FETCH.
  - 10 JUMP: PCWrite, PCSource=10. -> FETCH.
  - 11 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
  - 12 ADDIWB: RegWrite, RegDst=0, MemtoReg=0. -> FETCH.
  - 13 ILLEGAL: illegal_op=1. -> FETCH. The instruction is skipped; PC has already advanced in FETCH.
  - 14, 15: unused. Must recover to FETCH on the next edge with all outputs 0.
- Latency in cycles, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
- instr_count increments by 1 on each clock edge where the next state is FETCH. It wraps from 2^CNTW-1 to 0 with no flag.
- opcode is assumed stable from the FETCH edge until the instruction completes, since IR is written only in FETCH. A change outside DECODE/MEMADDR has no effect.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- When defined:
  - Adds input port mem_ready (1 bit) and state 14 IFWAIT (MemRead=1, IorD=0, all else 0).
  - Every transition that would enter FETCH (including from INIT) enters IFWAIT instead.
  - IFWAIT holds while mem_ready=0 and moves to FETCH when mem_ready=1. This guarantees PCWrite and IRWrite last exactly one cycle.
  - MEMREAD and MEMWRITE hold, with strobes steady, while mem_ready=0.
  - instr_count counts FETCH entries only, never IFWAIT.
- When undefined: no mem_ready port, state 14 is unused, and timing is exactly as above.

Decomposition:
- Package mc_ctrl_pkg holds: state encoding constants (INIT..IFWAIT), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp / ALUSrcB / PCSource code constants, and a packed control-word typedef.
- One sub-module, mc_ctrl_decode: purely combinational state-to-control-word decode.
- Top level holds the state register, next-state logic and instr_count.

Test Plan:
- reset_n=0 mid-MEMREAD -> same cycle: state=0, all strobes 0, instr_count=0; after release, FETCH follows one edge later.
- opcode=0x23 held -> state sequence 1,2,3,4,5,1; MemtoReg=1 and RegWrite=1 only in state 5; instr_count +1 per loop.
- opcode sequence R-type, sw, beq, j -> loop lengths 4, 4, 3, 3; MemWrite only in state 6; PCWriteCond only in 9; PCSource=10 in 10.
- opcode=0x3F -> DECODE goes to 13, illegal_op=1 for exactly one cycle, then FETCH; no RegWrite or MemWrite asserted.
- Force state register to 15 -> FETCH next edge with outputs 0 in state 15; preload instr_count to 0xFFFFFFFF and enter FETCH -> count reads 0.
- MC_MEM_WAIT_EN defined, mem_ready low 3 cycles in IFWAIT and 2 in MEMREAD -> PCWrite pulses exactly once per instruction; lw loop takes 11 cycles.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings and control-word type for the multicycle control FSM
// State 14 (IFWAIT) is only reachable when MC_MEM_WAIT_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADDR  = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXEC     = 4'd7,
    RCOMP    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDIEX   = 4'd11,
    ADDIWB   = 4'd12,
    ILLEGAL  = 4'd13,
    IFWAIT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state-to-control-word decode
// MC_MEM_WAIT_EN adds the IFWAIT decode; otherwise state 14 decodes to all zeros.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADDR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RCOMP: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      ILLEGAL: ctrl.illegal_op = 1'b1;
`ifdef MC_MEM_WAIT_EN
      IFWAIT: ctrl.mem_read = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore multicycle CPU control unit with retired-fetch counter
// MC_MEM_WAIT_EN adds mem_ready and the IFWAIT state ahead of every FETCH.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opcode,
`ifdef MC_MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic [3:0]      state,
  output logic [CNTW-1:0] instr_count
);

`ifdef MC_MEM_WAIT_EN
  localparam state_t FETCH_ENTRY = IFWAIT;
  logic ready;
  assign ready = mem_ready;
`else
  localparam state_t FETCH_ENTRY = FETCH;
  logic ready;
  assign ready = 1'b1;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] count_q;
  ctrl_t           ctrl;

  // opcode only steers the DECODE and MEMADDR exits; everything else ignores it
  always_comb begin
    state_d = FETCH_ENTRY;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) state_d = MEMADDR;
        else if (opcode == OPW'(OP_RTYPE))                   state_d = EXEC;
        else if (opcode == OPW'(OP_BEQ))                     state_d = BRANCH;
        else if (opcode == OPW'(OP_J))                       state_d = JUMP;
        else if (opcode == OPW'(OP_ADDI))                    state_d = ADDIEX;
        else                                                 state_d = ILLEGAL;
      end
      MEMADDR:  state_d = (opcode == OPW'(OP_LW)) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = ready ? MEMWB : MEMREAD;
      MEMWRITE: state_d = ready ? FETCH_ENTRY : MEMWRITE;
      EXEC:     state_d = RCOMP;
      ADDIEX:   state_d = ADDIWB;
      IFWAIT:   state_d = ready ? FETCH : IFWAIT;
      default:  state_d = FETCH_ENTRY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == FETCH) count_q <= count_q + CNTW'(1);
    end
  end

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
// Builds with or without MC_MEM_WAIT_EN.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif
  localparam logic [3:0] F_ENTRY = WAIT ? 4'd14 : 4'd1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b1;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic        RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic [3:0]  m_state = 4'd0;
  logic [31:0] m_count = 32'd0;
  logic [52:0] sb[$];
  logic [52:0] e;

  always #5 clock = ~clock;

  mc_control_fsm dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .opcode      (opcode),
`ifdef MC_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .state       (state),
    .instr_count (instr_count)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s);
    case (s)
      4'd1:    return 17'b1_0_0_1_0_0_1_0_0_0_01_00_00_0;
      4'd2:    return 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
      4'd3:    return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      4'd4:    return 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
      4'd5:    return 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
      4'd6:    return 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
      4'd7:    return 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
      4'd8:    return 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
      4'd9:    return 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
      4'd10:   return 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
      4'd11:   return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      4'd12:   return 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
      4'd13:   return 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
      4'd14:   return WAIT ? 17'b0_0_0_1_0_0_0_0_0_0_00_00_00_0 : 17'd0;
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [5:0] op, input logic rdy);
    case (s)
      4'd1: return 4'd2;
      4'd2: begin
        case (op)
          6'h23, 6'h2B: return 4'd3;
          6'h00:        return 4'd7;
          6'h04:        return 4'd9;
          6'h02:        return 4'd10;
          6'h08:        return 4'd11;
          default:      return 4'd13;
        endcase
      end
      4'd3:    return (op == 6'h23) ? 4'd4 : 4'd6;
      4'd4:    return rdy ? 4'd5 : 4'd4;
      4'd6:    return rdy ? F_ENTRY : 4'd6;
      4'd7:    return 4'd8;
      4'd11:   return 4'd12;
      4'd14:   return WAIT ? (rdy ? 4'd1 : 4'd14) : F_ENTRY;
      default: return F_ENTRY;
    endcase
  endfunction

  function automatic logic [20:0] obs();
    return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
  endfunction

  task automatic advance();
    logic [3:0] ns;
    ns = model_next(m_state, opcode, WAIT ? mem_ready : 1'b1);
    if (ns == 4'd1) m_count = m_count + 32'd1;
    m_state = ns;
    sb.push_back({ns, exp_ctrl(ns), m_count});
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction starting in FETCH, checking every cycle against the scoreboard.
  task automatic run_instr(input logic [5:0] op, input int exp_len, input int exp_ill, input string nm);
    int len;
    int ill;
    logic [31:0] c0;
    len = 0;
    ill = 0;
    c0 = instr_count;
    opcode = op;
    do begin
      advance();
      len++;
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32]) $display("FAIL %s cyc%0d ctrl: got %h want %h", nm, len, obs(), e[52:32]);
      else n_pass++;
      n_total++;
      if (instr_count !== e[31:0]) $display("FAIL %s cyc%0d count: got %0d want %0d", nm, len, instr_count, e[31:0]);
      else n_pass++;
      ill += int'(illegal_op);
    end while (m_state != 4'd1 && len < 20);
    n_total++;
    if (len !== exp_len || state !== 4'd1) $display("FAIL %s loop: got %0d cycles want %0d", nm, len, exp_len);
    else n_pass++;
    n_total++;
    if (instr_count !== c0 + 32'd1) $display("FAIL %s retire: got %0d want %0d", nm, instr_count, c0 + 32'd1);
    else n_pass++;
    n_total++;
    if (ill !== exp_ill) $display("FAIL %s illegal pulses: got %0d want %0d", nm, ill, exp_ill);
    else n_pass++;
  endtask

  task automatic test_reset();
    int n;
    #1;
    n_total++;
    if (obs() !== 21'd0) $display("FAIL reset ctrl: got %h want 0", obs());
    else n_pass++;
    n_total++;
    if (instr_count !== 32'd0) $display("FAIL reset count: got %0d want 0", instr_count);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    do begin
      advance();
      n++;
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32] || instr_count !== e[31:0])
        $display("FAIL reset exit: got %h/%0d want %h/%0d", obs(), instr_count, e[52:32], e[31:0]);
      else n_pass++;
    end while (m_state != 4'd1 && n < 5);
    n_total++;
    if (instr_count !== 32'd1) $display("FAIL reset first fetch count: got %0d want 1", instr_count);
    else n_pass++;
  endtask

  task automatic test_lw();
    run_instr(6'h23, 5 + int'(WAIT), 0, "lw0");
    run_instr(6'h23, 5 + int'(WAIT), 0, "lw1");
  endtask

  task automatic test_back_to_back();
    run_instr(6'h00, 4 + int'(WAIT), 0, "rtype");
    run_instr(6'h2B, 4 + int'(WAIT), 0, "sw");
    run_instr(6'h04, 3 + int'(WAIT), 0, "beq");
    run_instr(6'h02, 3 + int'(WAIT), 0, "j");
    run_instr(6'h08, 4 + int'(WAIT), 0, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 3 + int'(WAIT), 1, "illegal");
    run_instr(6'h11, 3 + int'(WAIT), 1, "illegal2");
  endtask

  task automatic test_reset_mid();
    int n;
    opcode = 6'h23;
    n = 0;
    while (m_state != 4'd4 && n < 10) begin
      advance();
      n++;
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32]) $display("FAIL midrst approach: got %h want %h", obs(), e[52:32]);
      else n_pass++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (obs() !== 21'd0) $display("FAIL midrst ctrl: got %h want 0", obs());
    else n_pass++;
    n_total++;
    if (instr_count !== 32'd0) $display("FAIL midrst count: got %0d want 0", instr_count);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    m_state = 4'd0;
    m_count = 32'd0;
    advance();
    e = sb.pop_front();
    n_total++;
    if (state !== F_ENTRY || obs() !== e[52:32]) $display("FAIL midrst release: got %h want %h", obs(), e[52:32]);
    else n_pass++;
    if (WAIT) begin
      advance();
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32]) $display("FAIL midrst wait exit: got %h want %h", obs(), e[52:32]);
      else n_pass++;
    end
  endtask

  task automatic test_unused_wrap();
    int n;
    #2;
    force dut.state_q = state_t'(4'd15);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    n_total++;
    if (obs() !== {4'd15, 17'd0}) $display("FAIL unused15 ctrl: got %h want %h", obs(), {4'd15, 17'd0});
    else n_pass++;
    release dut.state_q;
    release dut.count_q;
    m_state = 4'd15;
    m_count = 32'hFFFF_FFFF;
    n = 0;
    do begin
      advance();
      n++;
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32] || instr_count !== e[31:0])
        $display("FAIL unused15 exit: got %h/%0d want %h/%0d", obs(), instr_count, e[52:32], e[31:0]);
      else n_pass++;
    end while (m_state != 4'd1 && n < 5);
    n_total++;
    if (instr_count !== 32'd0 || n !== 1 + int'(WAIT)) $display("FAIL wrap: got %0d after %0d edges want 0", instr_count, n);
    else n_pass++;
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    int len, mw, iw, pcw;
    len = 0; mw = 0; iw = 0; pcw = 0;
    opcode = 6'h23;
    do begin
      if (m_state == 4'd4 && mw < 2) begin mem_ready = 1'b0; mw++; end
      else if (m_state == 4'd14 && iw < 3) begin mem_ready = 1'b0; iw++; end
      else mem_ready = 1'b1;
      advance();
      len++;
      e = sb.pop_front();
      n_total++;
      if (obs() !== e[52:32] || instr_count !== e[31:0])
        $display("FAIL memwait cyc%0d: got %h/%0d want %h/%0d", len, obs(), instr_count, e[52:32], e[31:0]);
      else n_pass++;
      pcw += int'(PCWrite);
    end while (m_state != 4'd1 && len < 30);
    mem_ready = 1'b1;
    n_total++;
    if (len !== 11) $display("FAIL memwait loop: got %0d want 11", len);
    else n_pass++;
    n_total++;
    if (pcw !== 1) $display("FAIL memwait PCWrite pulses: got %0d want 1", pcw);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_illegal();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_reset_mid();
    test_unused_wrap();
    run_instr(6'h23, 5 + int'(WAIT), 0, "lw_after_wrap");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
